// File: rtl/xor_share_ctrl_pkg.sv
// Shared definitions for the shared-XOR controller: default sizes and FSM encoding.
package xor_share_ctrl_pkg;

  localparam int unsigned N_DEF = 4;  // default number of requesters
  localparam int unsigned W_DEF = 8;  // default operand/result width

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/xor_share_ctrl_rr_arbiter.sv
// Round-robin priority rotate: picks the first active requester after pointer.
// Ports:
//   req      in  N   request vector
//   pointer  in  IW  index of the last granted requester
//   grant    out IW  winning index (valid when any_req)
//   any_req  out 1   at least one request is active
module rr_arbiter
  import xor_share_ctrl_pkg::*;
#(
  parameter  int unsigned N  = N_DEF,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [IW-1:0] grant,
  output logic          any_req
);

  logic [IW-1:0] idx;

  // Scan offsets from farthest to nearest so the nearest active requester wins.
  always_comb begin
    grant   = '0;
    idx     = '0;
    any_req = |req;
    for (int unsigned off = N; off >= 1; off--) begin
      idx = IW'((32'(pointer) + off) % N);
      if (req[idx]) begin
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/xor_share_ctrl.sv
// Shares one registered XOR unit among N requesters with round-robin arbitration
// and a per-requester req/ack handshake; the result is broadcast with its owner index.
// Ports:
//   clock    in  1    system clock, rising edge
//   reset    in  1    asynchronous reset, active-high
//   req      in  N    per-requester operation request
//   a, b     in  N*W  operands; requester i occupies bits [i*W +: W]
//   ack      out N    one-cycle pulse to the served requester
//   z        out W    registered result, held between operations
//   z_valid  out 1    one-cycle pulse marking z/z_id valid
//   z_id     out IW   index of the requester owning z
module xor_share_ctrl
  import xor_share_ctrl_pkg::*;
#(
  parameter  int unsigned N  = N_DEF,
  parameter  int unsigned W  = W_DEF,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  a,
  input  logic [N*W-1:0]  b,
  output logic [N-1:0]    ack,
  output logic [W-1:0]    z,
  output logic            z_valid,
  output logic [IW-1:0]   z_id
);

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_q;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;

  logic [IW-1:0] grant;
  logic          any_req;
  logic [W-1:0]  sel_a;
  logic [W-1:0]  sel_b;

  rr_arbiter #(.N(N)) u_arb (
    .req     (req),
    .pointer (rr_ptr),
    .grant   (grant),
    .any_req (any_req)
  );

  // Operand mux for the current arbitration winner.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant == IW'(i)) begin
        sel_a = a[i*W +: W];
        sel_b = b[i*W +: W];
      end
    end
  end

  // Control FSM with operand latches and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      rr_ptr  <= IW'(N - 1);
      gnt_q   <= '0;
      op_a    <= '0;
      op_b    <= '0;
      ack     <= '0;
      z       <= '0;
      z_valid <= 1'b0;
      z_id    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ack     <= '0;
          z_valid <= 1'b0;
          if (any_req) begin
            gnt_q  <= grant;
            op_a   <= sel_a;
            op_b   <= sel_b;
            rr_ptr <= grant;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          z       <= op_a ^ op_b;
          z_id    <= gnt_q;
          z_valid <= 1'b1;
          ack     <= N'(1) << gnt_q;
          state   <= S_DONE;
        end
        S_DONE: begin
          // Guard cycle: the served requester drops req before the next arbitration.
          ack     <= '0;
          z_valid <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          ack     <= '0;
          z       <= '0;
          z_valid <= 1'b0;
          z_id    <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_share_ctrl.sv
// Directed self-checking bench for xor_share_ctrl (N=4, W=8).
module tb_xor_share_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic         clock;
  logic         reset;
  logic [3:0]   req;
  logic [31:0]  a;
  logic [31:0]  b;
  logic [3:0]   ack;
  logic [7:0]   z;
  logic         z_valid;
  logic [1:0]   z_id;

  int vectors;
  int miscompares;

  logic [3:0] gm[8];
  int         at_cyc[8];

  xor_share_ctrl #(.N(N), .W(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .a       (a),
    .b       (b),
    .ack     (ack),
    .z       (z),
    .z_valid (z_valid),
    .z_id    (z_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drive one request and wait (bounded) for its z_valid; returns observations.
  task automatic do_op(input int idx, input logic [7:0] av, input logic [7:0] bv,
                       output int lat, output logic [3:0] ack_o,
                       output logic [7:0] z_o, output logic [1:0] id_o);
    @(negedge clock);
    req[idx] = 1'b1;
    a[idx*8 +: 8] = av;
    b[idx*8 +: 8] = bv;
    lat = -1; ack_o = '0; z_o = '0; id_o = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (z_valid) begin
        lat = c; ack_o = ack; z_o = z; id_o = z_id;
        break;
      end
    end
    req[idx] = 1'b0;
    @(negedge clock);
  endtask

  // Hold requesters in mask, each dropping req for one cycle after its ack.
  task automatic run_rr(input logic [3:0] mask, input int n, output int ngot);
    int cyc;
    logic [3:0] rearm;
    cyc = 0; rearm = '0; ngot = 0;
    @(negedge clock);
    req = mask;
    while (ngot < n && cyc < 60) begin
      @(negedge clock);
      cyc++;
      req = req | rearm;
      rearm = '0;
      if (ack != 4'b0000) begin
        gm[ngot] = ack;
        at_cyc[ngot] = cyc;
        ngot++;
        req = req & ~ack;
        rearm = ack;
      end
    end
    req = '0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    vectors++;
    if (ack !== 4'b0000 || z_valid !== 1'b0 || z !== 8'h00 || z_id !== 2'd0) begin
      $display("FAIL reset_values: ack=%b z_valid=%b z=%h z_id=%0d, want 0/0/00/0", ack, z_valid, z, z_id);
      miscompares++;
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    vectors++;
    if (ack !== 4'b0000 || z_valid !== 1'b0) begin
      $display("FAIL idle_after_reset: ack=%b z_valid=%b, want 0000/0", ack, z_valid);
      miscompares++;
    end
  endtask

  task automatic test_basic();
    int lat; logic [3:0] ak; logic [7:0] zz; logic [1:0] id;
    do_op(2, 8'hA5, 8'h0F, lat, ak, zz, id);
    vectors++;
    if (lat !== 2) begin
      $display("FAIL basic_latency: got %0d cycles, want 2", lat); miscompares++;
    end
    vectors++;
    if (ak !== 4'b0100) begin
      $display("FAIL basic_ack: got %b, want 0100", ak); miscompares++;
    end
    vectors++;
    if (zz !== 8'hAA || id !== 2'd2) begin
      $display("FAIL basic_result: z=%h id=%0d, want aa/2", zz, id); miscompares++;
    end
    vectors++;
    if (z_valid !== 1'b0 || ack !== 4'b0000 || z !== 8'hAA) begin
      $display("FAIL basic_pulse_end: z_valid=%b ack=%b z=%h, want 0/0000/aa", z_valid, ack, z);
      miscompares++;
    end
  endtask

  task automatic test_xor_values();
    int lat; logic [3:0] ak; logic [7:0] zz; logic [1:0] id;
    do_op(0, 8'hFF, 8'hFF, lat, ak, zz, id);
    vectors++;
    if (zz !== 8'h00 || id !== 2'd0 || ak !== 4'b0001) begin
      $display("FAIL xor_ff_ff: z=%h id=%0d ack=%b, want 00/0/0001", zz, id, ak); miscompares++;
    end
    do_op(0, 8'h00, 8'hFF, lat, ak, zz, id);
    vectors++;
    if (zz !== 8'hFF || id !== 2'd0) begin
      $display("FAIL xor_00_ff: z=%h id=%0d, want ff/0", zz, id); miscompares++;
    end
    repeat (4) @(negedge clock);
    vectors++;
    if (z !== 8'hFF || z_id !== 2'd0 || z_valid !== 1'b0) begin
      $display("FAIL z_hold: z=%h z_id=%0d z_valid=%b, want ff/0/0", z, z_id, z_valid);
      miscompares++;
    end
  endtask

  task automatic test_round_robin();
    int ngot;
    logic [3:0] exp_m[5];
    exp_m = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    a = 32'h44332211;
    b = 32'h0F0F0F0F;
    run_rr(4'b1111, 5, ngot);
    vectors++;
    if (ngot !== 5) begin
      $display("FAIL rr_count: got %0d grants, want 5", ngot); miscompares++;
    end
    for (int k = 0; k < 5 && k < ngot; k++) begin
      vectors++;
      if (gm[k] !== exp_m[k]) begin
        $display("FAIL rr_order[%0d]: ack=%b, want %b", k, gm[k], exp_m[k]); miscompares++;
      end
      if (k > 0) begin
        vectors++;
        if (at_cyc[k] - at_cyc[k-1] !== 3) begin
          $display("FAIL rr_spacing[%0d]: %0d cycles, want 3", k, at_cyc[k] - at_cyc[k-1]);
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_wrap();
    int lat; int ngot; logic [3:0] ak; logic [7:0] zz; logic [1:0] id;
    logic [3:0] exp_m[3];
    exp_m = '{4'b1000, 4'b0010, 4'b1000};
    do_op(1, 8'h5A, 8'h5A, lat, ak, zz, id);
    vectors++;
    if (id !== 2'd1 || zz !== 8'h00) begin
      $display("FAIL wrap_pre_grant: id=%0d z=%h, want 1/00", id, zz); miscompares++;
    end
    run_rr(4'b1010, 3, ngot);
    vectors++;
    if (ngot !== 3) begin
      $display("FAIL wrap_count: got %0d grants, want 3", ngot); miscompares++;
    end
    for (int k = 0; k < 3 && k < ngot; k++) begin
      vectors++;
      if (gm[k] !== exp_m[k]) begin
        $display("FAIL wrap_order[%0d]: ack=%b, want %b", k, gm[k], exp_m[k]); miscompares++;
      end
    end
  endtask

  task automatic test_req_drop();
    int extra;
    @(negedge clock);
    req[1] = 1'b1; a[15:8] = 8'h3C; b[15:8] = 8'hC3;
    @(negedge clock);
    req[1] = 1'b0; a[15:8] = 8'h00; b[15:8] = 8'h00;
    @(negedge clock);
    vectors++;
    if (ack !== 4'b0010 || z_valid !== 1'b1 || z !== 8'hFF || z_id !== 2'd1) begin
      $display("FAIL drop_complete: ack=%b z_valid=%b z=%h id=%0d, want 0010/1/ff/1", ack, z_valid, z, z_id);
      miscompares++;
    end
    extra = 0;
    repeat (6) begin
      @(negedge clock);
      if (ack !== 4'b0000 || z_valid !== 1'b0) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      $display("FAIL drop_no_regrant: %0d cycles with activity, want 0", extra); miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clock);
    a[23:16] = 8'h12; b[23:16] = 8'h34;
    a[31:24] = 8'h56; b[31:24] = 8'h78;
    req = 4'b1100;
    @(negedge clock);
    reset = 1'b1;
    #1;
    vectors++;
    if (ack !== 4'b0000 || z_valid !== 1'b0 || z !== 8'h00 || z_id !== 2'd0) begin
      $display("FAIL reset_async: ack=%b z_valid=%b z=%h id=%0d, want 0000/0/00/0", ack, z_valid, z, z_id);
      miscompares++;
    end
    @(negedge clock);
    vectors++;
    if (ack !== 4'b0000 || z_valid !== 1'b0) begin
      $display("FAIL reset_no_ack: ack=%b z_valid=%b, want 0000/0", ack, z_valid); miscompares++;
    end
    reset = 1'b0;
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (z_valid) begin lat = c; break; end
    end
    vectors++;
    if (lat !== 2 || ack !== 4'b0100 || z !== 8'h26 || z_id !== 2'd2) begin
      $display("FAIL reset_regrant: lat=%0d ack=%b z=%h id=%0d, want 2/0100/26/2", lat, ack, z, z_id);
      miscompares++;
    end
    req = '0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    req = '0;
    a = '0;
    b = '0;
    @(negedge clock);
    test_reset();
    test_basic();
    test_xor_values();
    test_round_robin();
    test_wrap();
    test_req_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
